switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Router-level switch allocator for the 5-port mesh router; ports are N, E, W, S, L.
- Owns all five output ports. Each output is arbitrated among the input ports that request it, using sticky round-robin.
- Drives the per-output RTS/DCTS handshake toward the downstream router, the per-input grants back to the input FIFOs, and the crossbar select for every output column.
- Sits between the input-buffer routing logic (which produces the requests) and the crossbar.

Parameters:
- NPORTS, 5, number of router ports. Index order: N=0, E=1, W=2, S=3, L=4. Fixed at 5 in this release.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req  input  25  request matrix; bit i*5+o set = input i requests output o
- dcts  input  5  downstream clear-to-send, one bit per output o
- rts  output  5  request-to-send, one bit per output o (registered)
- grant  output  25  bit i*5+o = input i may dequeue one flit to output o this cycle
- xbar_sel  output  25  column o*5+i = one-hot owner select for output o; all zero when idle

Behaviour:
- Each output o runs an independent FSM with states IDLE and OWN_i (i = 0..4), using 6-bit one-hot encoding; IDLE = 6'b000001.
- Diagonal request bits (i == o) are masked and never granted.
- At most one bit set per req row; an RTL assertion flags any violation.
- Owner selection (next_owner, combinational):
  - In OWN_i: if req[i][o] is still set, keep i. Otherwise search cyclically starting at i+1 (N→E→W→S→L→N) for the first requesting input.
  - In IDLE: search cyclically starting at last_owner+1.
  - If nothing requests, next state is IDLE.
- last_owner per output: updated to i whenever the FSM enters OWN_i. Reset value is S(3), so the first priority after reset is L, then N, E, W, S.
- State register update per output:
  - If rts[o] = 1 and dcts[o] = 0: hold the state.
  - Otherwise: state <= next_owner.
- rts register per output, next value:
  - 0 when the state is IDLE.
  - 0 when rts & dcts (one-cycle drop after each transfer).
  - 1 otherwise.
- grant[i*5+o] = (state == OWN_i) & rts[o] & dcts[o]. Combinational; at most one grant per output column.
- xbar_sel[o] = one-hot of the current owner. Valid from the first cycle in OWN_i; all zero in IDLE.
- Latency from a request sampled at edge t with output o IDLE:
  - state = OWN_i and xbar_sel valid in cycle t+1.
  - rts = 1 in cycle t+2.
  - Earliest grant in cycle t+2 if dcts = 1.
  - Steady-state throughput for a held request: one grant every 2 cycles.
- Simultaneous events:
  - Several inputs request the same idle output: the round-robin winner from last_owner+1 takes it.
  - The owner drops its request in the same cycle as the grant: the next owner is chosen from owner+1.
- Different outputs are fully independent. One input may own only one output at a time, which the one-hot row rule guarantees.
- Reset, including mid-transfer: all FSMs go to IDLE, rts = 0, grant = 0, xbar_sel = 0, last_owner = S. Reset has priority over dcts.

Decomposition:
- Package router_pkg holds:
  - NPORTS
  - port index constants P_N, P_E, P_W, P_S, P_L
  - the one-hot state encoding constants ST_IDLE and ST_OWN[5]
  - a function rr_pick(req_vec, start_idx) returning the one-hot winner
- Sub-module output_port_alloc: one output's FSM, last_owner register, rts register and grant/select column. It is instantiated 5 times in switch_allocator via a generate loop.
- The top level only masks the diagonal and transposes the req/grant matrices.

Test Plan:
- Reset then req[L→N]=1, dcts[N]=1 → xbar_sel[N]=L in cycle 1, rts[N]=1 in cycle 2, grant[L*5+N]=1 in cycle 2, rts[N]=0 in cycle 3, grant repeats every 2 cycles.
- E, W and S all request output L, dcts[L]=1, last_owner=S(reset) → grants go E, W, S in order. E is held while E still requests; on E's release the next owner is W.
- Owner N on output E with dcts[E]=0 for 4 cycles → rts[E] stays 1, state and xbar_sel are frozen, no grant. dcts[E]=1 on cycle 5 → exactly one grant pulse.
- Diagonal req[N→N]=1 alone → output N stays IDLE, rts[N]=0, grant=0.
- Five outputs each requested by a distinct input, all dcts=1 → all five rts rise together and five independent grants occur in the same cycle.
- rst asserted while rts=1 and dcts=0 → next cycle all rts=0, grant=0, xbar_sel=0. Re-request from W and S to output L → W wins, following reset priority L, N, E, W, S.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants: port indices, one-hot allocator state encoding and
// the round-robin picker used by every output-port arbiter.
package router_pkg;

    localparam int NPORTS  = 5;
    localparam int PIDX_W  = 3;

    localparam logic [PIDX_W-1:0] P_N = 3'd0;
    localparam logic [PIDX_W-1:0] P_E = 3'd1;
    localparam logic [PIDX_W-1:0] P_W = 3'd2;
    localparam logic [PIDX_W-1:0] P_S = 3'd3;
    localparam logic [PIDX_W-1:0] P_L = 3'd4;

    // Bit 0 is IDLE, bit i+1 is OWN_i.
    typedef logic [NPORTS:0] alloc_state_t;

    localparam alloc_state_t ST_IDLE = 6'b000001;
    localparam alloc_state_t ST_OWN [NPORTS] = '{
        6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000
    };

    function automatic logic [PIDX_W-1:0] rr_next(input logic [PIDX_W-1:0] idx);
        return (idx == P_L) ? P_N : idx + 3'd1;
    endfunction

    function automatic logic [PIDX_W-1:0] oh2idx(input logic [NPORTS-1:0] oh);
        logic [PIDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (oh[k[PIDX_W-1:0]]) idx = k[PIDX_W-1:0];
        end
        return idx;
    endfunction

    // First requester found walking N->E->W->S->L cyclically from start_idx.
    function automatic logic [NPORTS-1:0] rr_pick(input logic [NPORTS-1:0] req_vec,
                                                  input logic [PIDX_W-1:0] start_idx);
        logic [NPORTS-1:0] win;
        logic [PIDX_W-1:0] idx;
        win = '0;
        idx = start_idx;
        for (int k = 0; k < NPORTS; k++) begin
            if (win == '0 && req_vec[idx]) win[idx] = 1'b1;
            idx = rr_next(idx);
        end
        return win;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input-buffer routing logic, the allocator
// and the downstream RTS/DCTS handshake.
interface switch_allocator_if;
    import router_pkg::*;

    logic [NPORTS*NPORTS-1:0] req;
    logic [NPORTS-1:0]        dcts;
    logic [NPORTS-1:0]        rts;
    logic [NPORTS*NPORTS-1:0] grant;
    logic [NPORTS*NPORTS-1:0] xbar_sel;

    modport master (output req, dcts, input rts, grant, xbar_sel);
    modport slave  (input req, dcts, output rts, grant, xbar_sel);

endinterface

// File: rtl/switch_allocator_output_port_alloc.sv
// One output column: sticky round-robin owner FSM, last-owner pointer,
// RTS register and the combinational grant/select column.
module output_port_alloc
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req_col,
    input  logic              dcts,
    output logic              rts,
    output logic [NPORTS-1:0] grant_col,
    output logic [NPORTS-1:0] sel_col
);

    alloc_state_t      state_q, state_d;
    logic [PIDX_W-1:0] last_owner_q, last_owner_d;
    logic              rts_q, rts_d;

    logic [NPORTS-1:0] owner_oh;
    logic [NPORTS-1:0] pick;

    assign owner_oh = state_q[NPORTS:1];

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick         = '0;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        rts_d        = 1'b1;

        if (state_q == ST_IDLE) begin
            pick = rr_pick(req_col, rr_next(last_owner_q));
        end else if ((req_col & owner_oh) != '0) begin
            pick = owner_oh;
        end else begin
            pick = rr_pick(req_col, rr_next(oh2idx(owner_oh)));
        end

        // A raised RTS waiting on DCTS freezes the owner until the flit moves.
        if (!(rts_q && !dcts)) begin
            state_d = (pick == '0) ? ST_IDLE : ST_OWN[oh2idx(pick)];
        end

        if (state_d != ST_IDLE) last_owner_d = oh2idx(state_d[NPORTS:1]);

        if (state_q == ST_IDLE || (rts_q && dcts)) rts_d = 1'b0;
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= P_S;
            rts_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            rts_q        <= rts_d;
        end
    end

    assign rts       = rts_q;
    assign sel_col   = owner_oh;
    assign grant_col = owner_oh & {NPORTS{rts_q & dcts}};

endmodule

// File: rtl/switch_allocator.sv
// 5-port router switch allocator: masks the diagonal, transposes the request
// and grant matrices, and runs one round-robin arbiter per output.
module switch_allocator
    import router_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    switch_allocator_if.slave   sa
);

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        logic [NPORTS-1:0] req_col;
        logic [NPORTS-1:0] grant_col;
        logic [NPORTS-1:0] sel_col;
        logic              rts_o;

        for (genvar i = 0; i < NPORTS; i++) begin : g_in
            // An input never turns back out of the port it arrived on.
            assign req_col[i] = (i != o) ? sa.req[i*NPORTS+o] : 1'b0;
            assign sa.grant[i*NPORTS+o] = grant_col[i];
        end

        output_port_alloc u_alloc (
            .clk       (clk),
            .rst       (rst),
            .req_col   (req_col),
            .dcts      (sa.dcts[o]),
            .rts       (rts_o),
            .grant_col (grant_col),
            .sel_col   (sel_col)
        );

        assign sa.rts[o]                       = rts_o;
        assign sa.xbar_sel[o*NPORTS +: NPORTS] = sel_col;
    end

    // Each input row targets at most one output.
    for (genvar r = 0; r < NPORTS; r++) begin : g_row_chk
        always_ff @(posedge clk) begin
            if (!rst) begin
                assert ($onehot0(sa.req[r*NPORTS +: NPORTS]))
                    else $error("req row %0d has more than one output set", r);
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed plan steps plus randomized traffic, compared cycle by cycle
// against a per-output owner/last/rts reference model.
module tb_switch_allocator;

    localparam int NP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_allocator_if sa_if ();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .sa  (sa_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner input per output (-1 = nobody), last owner, rts.
    int m_owner [NP];
    int m_last  [NP];
    bit m_rts   [NP];

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit wants(input int i, input int o);
        logic [24:0] r;
        r = sa_if.req;
        return (i != o) && r[i*NP+o];
    endfunction

    task automatic model_step();
        logic [4:0] d;
        d = sa_if.dcts;
        for (int o = 0; o < NP; o++) begin
            if (rst) begin
                m_owner[o] = -1;
                m_last[o]  = 3;
                m_rts[o]   = 1'b0;
            end else begin
                bit new_rts;
                new_rts = (m_owner[o] >= 0) && !(m_rts[o] && d[o]);
                if (!(m_rts[o] && !d[o])) begin
                    if (!(m_owner[o] >= 0 && wants(m_owner[o], o))) begin
                        int start;
                        start = ((m_owner[o] >= 0) ? m_owner[o] : m_last[o]) + 1;
                        m_owner[o] = -1;
                        for (int k = 0; k < NP; k++) begin
                            if (m_owner[o] < 0 && wants((start + k) % NP, o))
                                m_owner[o] = (start + k) % NP;
                        end
                    end
                    if (m_owner[o] >= 0) m_last[o] = m_owner[o];
                end
                m_rts[o] = new_rts;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [4:0]  e_rts;
        logic [24:0] e_grant, e_sel;
        logic [4:0]  d;
        d       = sa_if.dcts;
        e_rts   = '0;
        e_grant = '0;
        e_sel   = '0;
        for (int o = 0; o < NP; o++) begin
            e_rts[o] = m_rts[o];
            if (m_owner[o] >= 0) begin
                e_sel[o*NP + m_owner[o]] = 1'b1;
                if (m_rts[o] && d[o]) e_grant[m_owner[o]*NP + o] = 1'b1;
            end
        end
        check({tag, ".rts"},   {20'b0, sa_if.rts}, {20'b0, e_rts});
        check({tag, ".grant"}, sa_if.grant,        e_grant);
        check({tag, ".xbar"},  sa_if.xbar_sel,     e_sel);
    endtask

    // One clock: model samples the same inputs the DUT sees at the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sa_if.req  = '0;
        sa_if.dcts = '0;
        tick("rst");
        tick("rst");
        rst = 1'b0;
    endtask

    initial begin
        sa_if.req  = '0;
        sa_if.dcts = '0;
        for (int o = 0; o < NP; o++) begin
            m_owner[o] = -1;
            m_last[o]  = 3;
            m_rts[o]   = 1'b0;
        end
        do_reset();
        check("reset.rts",   {20'b0, sa_if.rts}, 25'd0);
        check("reset.grant", sa_if.grant,        25'd0);
        check("reset.xbar",  sa_if.xbar_sel,     25'd0);

        // L requests N with DCTS high.
        sa_if.req  = 25'd1 << 20;
        sa_if.dcts = 5'b00001;
        tick("ln.t1");
        check("ln.xbar_t1", {20'b0, sa_if.xbar_sel[4:0]}, 25'b10000);
        check("ln.rts_t1",  {24'b0, sa_if.rts[0]},        25'd0);
        tick("ln.t2");
        check("ln.rts_t2",   {24'b0, sa_if.rts[0]}, 25'd1);
        check("ln.grant_t2", sa_if.grant,           25'd1 << 20);
        tick("ln.t3");
        check("ln.rts_t3",   {24'b0, sa_if.rts[0]}, 25'd0);
        check("ln.grant_t3", sa_if.grant,           25'd0);
        tick("ln.t4");
        check("ln.grant_t4", sa_if.grant,           25'd1 << 20);

        // E, W, S contend for L from reset priority.
        do_reset();
        sa_if.req  = (25'd1 << 9) | (25'd1 << 14) | (25'd1 << 19);
        sa_if.dcts = 5'b10000;
        tick("rr.t1");
        check("rr.xbar_e", {20'b0, sa_if.xbar_sel[24:20]}, 25'b00010);
        tick("rr.t2");
        check("rr.grant_e1", sa_if.grant, 25'd1 << 9);
        tick("rr.t3");
        tick("rr.t4");
        check("rr.grant_e2", sa_if.grant, 25'd1 << 9);
        sa_if.req = (25'd1 << 14) | (25'd1 << 19);
        tick("rr.t5");
        check("rr.xbar_w", {20'b0, sa_if.xbar_sel[24:20]}, 25'b00100);
        tick("rr.t6");
        check("rr.grant_w", sa_if.grant, 25'd1 << 14);
        sa_if.req = 25'd1 << 19;
        tick("rr.t7");
        check("rr.xbar_s", {20'b0, sa_if.xbar_sel[24:20]}, 25'b01000);
        tick("rr.t8");
        check("rr.grant_s", sa_if.grant, 25'd1 << 19);

        // N owns E while DCTS is low.
        do_reset();
        sa_if.req  = 25'd1 << 1;
        sa_if.dcts = 5'b00000;
        tick("hold.t1");
        tick("hold.t2");
        for (int c = 0; c < 4; c++) begin
            tick("hold.wait");
            check("hold.rts",   {24'b0, sa_if.rts[1]},           25'd1);
            check("hold.xbar",  {20'b0, sa_if.xbar_sel[9:5]},    25'b00001);
            check("hold.grant", sa_if.grant,                     25'd0);
        end
        sa_if.dcts = 5'b00010;
        #1;
        check("hold.grant_pulse", sa_if.grant, 25'd1 << 1);
        sa_if.req = '0;
        tick("hold.after1");
        check("hold.no_second", sa_if.grant, 25'd0);
        tick("hold.after2");
        check("hold.idle", {20'b0, sa_if.rts}, 25'd0);

        // Diagonal request is never served.
        do_reset();
        sa_if.req  = 25'd1;
        sa_if.dcts = 5'b11111;
        for (int c = 0; c < 3; c++) begin
            tick("diag");
            check("diag.rts",   {20'b0, sa_if.rts}, 25'd0);
            check("diag.xbar",  sa_if.xbar_sel,     25'd0);
            check("diag.grant", sa_if.grant,        25'd0);
        end

        // Permutation: input i -> output (i+1)%5, all outputs in parallel.
        do_reset();
        sa_if.req = '0;
        for (int i = 0; i < NP; i++) sa_if.req[i*NP + (i+1)%NP] = 1'b1;
        sa_if.dcts = 5'b11111;
        tick("perm.t1");
        tick("perm.t2");
        check("perm.rts",   {20'b0, sa_if.rts}, 25'b11111);
        check("perm.grant", sa_if.grant,        sa_if.req);

        // Reset while every RTS waits on DCTS.
        do_reset();
        sa_if.req = '0;
        for (int i = 0; i < NP; i++) sa_if.req[i*NP + (i+1)%NP] = 1'b1;
        sa_if.dcts = 5'b00000;
        tick("mid.t1");
        tick("mid.t2");
        check("mid.rts_up", {20'b0, sa_if.rts}, 25'b11111);
        rst = 1'b1;
        tick("mid.rst");
        check("mid.rts0",   {20'b0, sa_if.rts}, 25'd0);
        check("mid.grant0", sa_if.grant,        25'd0);
        check("mid.xbar0",  sa_if.xbar_sel,     25'd0);
        rst = 1'b0;
        sa_if.req  = (25'd1 << 14) | (25'd1 << 19);
        sa_if.dcts = 5'b10000;
        tick("mid.rereq");
        check("mid.xbar_w", {20'b0, sa_if.xbar_sel[24:20]}, 25'b00100);

        // Randomized traffic with sticky requests and occasional reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int t;
                    t = $urandom_range(0, 6);
                    sa_if.req[i*NP +: NP] = (t < NP) ? 5'(1 << t) : 5'b0;
                end
            end
            sa_if.dcts = 5'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            tick("rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
